// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command initiator for the accumulator ALU breadboard.
// Holds a program of {opcode, operand} entries, issues one entry per cycle on
// opcode/A, captures the ALU result bus (acc_in) for every issued entry into a
// small result FIFO and pulses done once the FIFO has drained.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid/ld_data/ld_ready program-load handshake (append to program)
//   clear                    empty the program (IDLE only, wins over start)
//   start                    begin a run (IDLE only)
//   busy, done               run status; done is a one-cycle pulse
//   opcode, A                registered ALU command; 0 whenever nothing issued
//   acc_in                   ALU combinational next-accumulator value
//   res_valid/res_data/res_op/res_ready  result FIFO head and pop handshake
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RES_DEPTH = 4,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [19:0] ld_data,
  output logic        ld_ready,
  input  logic        clear,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  opcode,
  output logic [15:0] A,
  input  logic [31:0] acc_in,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [3:0]  res_op,
  input  logic        res_ready
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned PtrW   = $clog2(DEPTH) + 1;
  localparam int unsigned FAddrW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(RES_DEPTH + 1);

  localparam logic [PtrW-1:0]   DepthP    = PtrW'(DEPTH);
  localparam logic [CntW-1:0]   ResDepthC = CntW'(RES_DEPTH);
  localparam logic [FAddrW-1:0] FLast     = FAddrW'(RES_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [19:0] prog_mem [DEPTH];
  logic [35:0] res_mem  [RES_DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   pc_q, pc_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [15:0]       a_q, a_d;
  logic              iss_q, iss_d;
  logic              done_q, done_d;
  logic [FAddrW-1:0] fifo_head_q, fifo_head_d;
  logic [FAddrW-1:0] fifo_tail_q, fifo_tail_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic [19:0]       cur_entry;
  logic [3:0]        cur_op;
  logic              ld_fire;
  logic              push;
  logic              pop;
  logic [CntW-1:0]   cnt_post;
  logic              prog_end;
  logic              can_issue;
  logic              start_ok;

  function automatic logic [FAddrW-1:0] fifo_inc(input logic [FAddrW-1:0] p);
    return (p == FLast) ? '0 : p + 1'b1;
  endfunction

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      pc_q        <= '0;
      opcode_q    <= '0;
      a_q         <= '0;
      iss_q       <= 1'b0;
      done_q      <= 1'b0;
      fifo_head_q <= '0;
      fifo_tail_q <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_q        <= pc_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      iss_q       <= iss_d;
      done_q      <= done_d;
      fifo_head_q <= fifo_head_d;
      fifo_tail_q <= fifo_tail_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Storage arrays are not reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      prog_mem[wr_ptr_q[AddrW-1:0]] <= ld_data;
    end
    if (push) begin
      res_mem[fifo_tail_q] <= {opcode_q, acc_in};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok && (wr_ptr_q != '0)) state_d = StRun;
      StRun:   if (prog_end) state_d = StDrain;
      StDrain: if (fifo_cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cur_entry = prog_mem[pc_q[AddrW-1:0]];
    cur_op    = cur_entry[19:16];
    start_ok  = (state_q == StIdle) && start && !clear;
    ld_fire   = ld_valid && ld_ready && !clear;

    // The entry currently on opcode/A is captured at this edge; the ALU
    // accumulator updates at the same edge, so acc_in is that entry's result.
    push     = iss_q;
    pop      = res_ready && (fifo_cnt_q != '0);
    cnt_post = fifo_cnt_q + CntW'(push) - CntW'(pop);

    prog_end  = (pc_q >= wr_ptr_q) || (cur_op == HALT_OP);
    // Only issue when the result will have a FIFO slot at the following edge.
    can_issue = (state_q == StRun) && !prog_end && (cnt_post < ResDepthC);

    wr_ptr_d = wr_ptr_q;
    if ((state_q == StIdle) && clear) begin
      wr_ptr_d = '0;
    end else if (ld_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    pc_d     = pc_q;
    opcode_d = '0;
    a_d      = '0;
    iss_d    = 1'b0;
    if (start_ok && (wr_ptr_q != '0)) begin
      pc_d = '0;
    end else if (can_issue) begin
      pc_d     = pc_q + 1'b1;
      opcode_d = cur_op;
      a_d      = cur_entry[15:0];
      iss_d    = 1'b1;
    end

    done_d = (start_ok && (wr_ptr_q == '0)) ||
             ((state_q == StDrain) && (fifo_cnt_q == '0));

    fifo_head_d = pop  ? fifo_inc(fifo_head_q) : fifo_head_q;
    fifo_tail_d = push ? fifo_inc(fifo_tail_q) : fifo_tail_q;
    fifo_cnt_d  = cnt_post;
  end

  // Outputs.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    ld_ready  = (state_q == StIdle) && (wr_ptr_q < DepthP) && !start && !rst;
    opcode    = opcode_q;
    A         = a_q;
    res_valid = (fifo_cnt_q != '0);
    {res_op, res_data} = res_mem[fifo_head_q];
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU breadboard.
// Expected results are computed per program by folding the ALU function over
// the entries up to the first HALT, then compared against popped FIFO data.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [19:0] ld_data;
  logic        ld_ready;
  logic        clear;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  opcode;
  logic [15:0] alu_a;
  logic [31:0] acc_in;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_op;
  logic        res_ready;

  int n_checks = 0;
  int n_errors = 0;

  alu_cmd_sequencer #(
    .DEPTH(16),
    .RES_DEPTH(4),
    .HALT_OP(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .clear(clear),
    .start(start),
    .busy(busy),
    .done(done),
    .opcode(opcode),
    .A(alu_a),
    .acc_in(acc_in),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_op(res_op),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // ALU breadboard: acc_in is the combinational next accumulator.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [31:0] acc_v);
    case (op)
      4'd1:    return 32'h0;
      4'd2:    return {16'h0, a};
      4'd3:    return acc_v - {16'h0, a};
      4'd4:    return acc_v ^ {16'h0, a};
      4'd5:    return acc_v + {16'h0, a};
      4'd6:    return acc_v << 1;
      4'd7:    return {acc_v[15:0], a};
      default: return acc_v;
    endcase
  endfunction

  logic [31:0] acc = 32'h0;
  assign acc_in = alu_f(opcode, alu_a, acc);
  always @(posedge clk) acc <= acc_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled mid-cycle.
  logic [35:0] popped[$];
  logic [3:0]  ops_seen[$];
  int          iss_cyc[$];
  int          done_cnt = 0;
  int          rv_first_cyc = -1;
  int          idle_issue = 0;
  int          bad_a = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) popped.push_back({res_op, res_data});
      if (done) done_cnt++;
      if (opcode != 4'd0) begin
        ops_seen.push_back(opcode);
        iss_cyc.push_back(cyc);
        if (!busy) idle_issue++;
      end else if (alu_a != 16'd0) begin
        bad_a++;
      end
      if (res_valid && rv_first_cyc < 0) rv_first_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [19:0] prog[$];
  logic [35:0] exp_res[$];
  logic [3:0]  exp_ops[$];

  task automatic build_expected();
    logic [31:0] a;
    logic [3:0]  op;
    exp_res.delete();
    exp_ops.delete();
    a = acc;
    for (int i = 0; i < prog.size(); i++) begin
      op = prog[i][19:16];
      if (op == 4'hF) break;
      a = alu_f(op, prog[i][15:0], a);
      exp_res.push_back({op, a});
      if (op != 4'd0) exp_ops.push_back(op);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("ld_ready_in_rst", {63'd0, ld_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    prog.delete();
  endtask

  task automatic load_entry(input logic [19:0] e);
    bit ok;
    @(posedge clk); #1;
    ld_valid = 1'b1;
    ld_data  = e;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ld_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check_eq("load_timeout", 64'd0, 64'd1);
    else prog.push_back(e);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int rr_pct, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      res_ready = ($urandom_range(0, 99) < rr_pct);
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      check_eq("done_timeout", 64'd0, 64'd1);
      do_reset();
      prog.delete();
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic clear_monitor();
    popped.delete();
    ops_seen.delete();
    iss_cyc.delete();
    rv_first_cyc = -1;
  endtask

  task automatic compare_run(input int d0);
    int n;
    check_eq("res_count", 64'(popped.size()), 64'(exp_res.size()));
    n = (popped.size() < exp_res.size()) ? popped.size() : exp_res.size();
    for (int i = 0; i < n; i++) check_eq("res_entry", 64'(popped[i]), 64'(exp_res[i]));
    check_eq("op_count", 64'(ops_seen.size()), 64'(exp_ops.size()));
    n = (ops_seen.size() < exp_ops.size()) ? ops_seen.size() : exp_ops.size();
    for (int i = 0; i < n; i++) check_eq("op_seq", 64'(ops_seen[i]), 64'(exp_ops[i]));
    check_eq("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic run_and_check(input int rr_pct);
    int d0;
    build_expected();
    clear_monitor();
    d0 = done_cnt;
    pulse_start();
    wait_done(rr_pct, 600);
    compare_run(d0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int fall_k;
    int d0;
    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; clear = 1'b0; start = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("ld_ready_in_rst", {63'd0, ld_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_opcode", 64'(opcode), 64'd0);
    check_eq("rst_a", 64'(alu_a), 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check_eq("rst_ld_ready", {63'd0, ld_ready}, 64'd1);

    // 1: basic accumulate program, always ready.
    load_entry({4'd1, 16'd0});
    for (int i = 0; i < 3; i++) load_entry({4'd5, 16'd1});
    run_and_check(100);
    check_eq("t1_res2", 64'(exp_res[2]), {28'd0, 4'd5, 32'd2});
    check_eq("t1_consecutive", 64'(iss_cyc[3] - iss_cyc[0]), 64'd3);
    check_eq("t1_res_latency", 64'(rv_first_cyc - iss_cyc[0]), 64'd1);

    // 2: consumer stalled, FIFO fills and the sequencer holds off.
    do_clear();
    load_entry({4'd1, 16'd0});
    for (int i = 0; i < 5; i++) load_entry({4'd5, 16'd1});
    build_expected();
    clear_monitor();
    d0 = done_cnt;
    pulse_start();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_eq("t2_full_valid", {63'd0, res_valid}, 64'd1);
    check_eq("t2_stall_opcode", 64'(opcode), 64'd0);
    check_eq("t2_acc_hold", 64'(acc), 64'd3);
    check_eq("t2_busy", {63'd0, busy}, 64'd1);
    check_eq("t2_no_pops", 64'(popped.size()), 64'd0);
    wait_done(100, 600);
    compare_run(d0);

    // 3: HALT stops issue.
    do_clear();
    load_entry({4'd1, 16'd0});
    load_entry({4'd5, 16'd15});
    load_entry({4'hF, 16'd0});
    load_entry({4'd5, 16'd1});
    run_and_check(100);
    check_eq("t3_res1", 64'(popped.size() > 1 ? popped[1] : 36'd0), {28'd0, 4'd5, 32'd15});

    // 4: empty program.
    do_clear();
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    check_eq("t4_done", {63'd0, done}, 64'd1);
    check_eq("t4_busy", {63'd0, busy}, 64'd0);
    check_eq("t4_opcode", 64'(opcode), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t4_done_one_cycle", {63'd0, done}, 64'd0);

    // 5: 17 back-to-back load offers.
    do_clear();
    acc_cnt = 0;
    fall_k = -1;
    @(posedge clk); #1;
    ld_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ld_data = (k == 0) ? {4'd1, 16'd0} : {4'd5, 16'(k)};
      @(negedge clk);
      if (ld_ready) begin
        acc_cnt++;
        prog.push_back(ld_data);
      end else if (fall_k < 0) begin
        fall_k = k;
      end
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    check_eq("t5_accepts", 64'(acc_cnt), 64'd16);
    check_eq("t5_fall_after_16", 64'(fall_k), 64'd16);
    @(negedge clk);
    check_eq("t5_ld_ready_full", {63'd0, ld_ready}, 64'd0);
    run_and_check(100);

    // 6: reset in the middle of a run with results pending.
    do_clear();
    load_entry({4'd1, 16'd0});
    for (int i = 0; i < 5; i++) load_entry({4'd5, 16'd1});
    res_ready = 1'b0;
    pulse_start();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_pending", {63'd0, res_valid}, 64'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prog.delete();
    @(negedge clk);
    check_eq("t6_opcode", 64'(opcode), 64'd0);
    check_eq("t6_res_valid", {63'd0, res_valid}, 64'd0);
    check_eq("t6_busy", {63'd0, busy}, 64'd0);
    check_eq("t6_ld_ready", {63'd0, ld_ready}, 64'd1);
    pulse_start();
    @(negedge clk);
    check_eq("t6_empty_done", {63'd0, done}, 64'd1);

    // Randomized programs: fresh, rerun (retention) and append.
    for (int it = 0; it < 30; it++) begin
      int mode;
      int n;
      int rr;
      logic [3:0]  op;
      logic [15:0] a;
      mode = $urandom_range(0, 3);
      if (mode == 1 && prog.size() > 0) begin
        n = 0;
      end else if (mode == 2 && prog.size() < 16) begin
        n = $urandom_range(1, 16 - prog.size());
      end else begin
        do_clear();
        n = $urandom_range(1, 16);
      end
      for (int i = 0; i < n; i++) begin
        op = 4'($urandom_range(0, 15));
        a  = (op == 4'd0) ? 16'd0 : 16'($urandom_range(0, 65535));
        if (prog.size() == 0 && $urandom_range(0, 2) == 0) begin
          op = 4'd1;
          a  = 16'd0;
        end
        load_entry({op, a});
      end
      case ($urandom_range(0, 2))
        0:       rr = 25;
        1:       rr = 60;
        default: rr = 100;
      endcase
      run_and_check(rr);
    end

    check_eq("issue_while_idle", 64'(idle_issue), 64'd0);
    check_eq("a_nonzero_on_noop", 64'(bad_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
